// File: rtl/warmboot_sequencer.sv
// Multiboot controller: picks an iCE40 warmboot image from host request, button or idle
// timeout, then detaches USB, arms SB_WARMBOOT select and pulses BOOT.
module warmboot_sequencer #(
    parameter int NUM_IMAGES        = 4,
    parameter int DEFAULT_IMAGE     = 1,
    parameter int DEBOUNCE_CYCLES   = 48000,
    parameter int LONG_PRESS_CYCLES = 48000000,
    parameter int TIMEOUT_CYCLES    = 0,
    parameter int DETACH_CYCLES     = 480000,
    parameter int ARM_CYCLES        = 4
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] boot_req_image,
    input  logic       activity,
    input  logic       btn_n,
    output logic [1:0] image_sel,
    output logic       usb_detach,
    output logic [1:0] warmboot_s,
    output logic       warmboot_boot,
    output logic       busy
);

    localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LPW     = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int TOW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int SEQ_MAX = (DETACH_CYCLES > ARM_CYCLES) ? DETACH_CYCLES : ARM_CYCLES;
    localparam int SQW     = $clog2(SEQ_MAX + 1);

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LPW-1:0] LP_MAX   = LPW'(LONG_PRESS_CYCLES);
    localparam logic [LPW-1:0] LP_LAST  = LPW'(LONG_PRESS_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST  = TOW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [SQW-1:0] DET_LAST = SQW'(DETACH_CYCLES - 1);
    localparam logic [SQW-1:0] ARM_LAST = SQW'(ARM_CYCLES - 1);
    localparam logic [1:0]     LAST_IMG = 2'(NUM_IMAGES - 1);
    localparam logic [1:0]     DEF_IMG  = 2'(DEFAULT_IMAGE);
    localparam logic [2:0]     NUM_IMG3 = 3'(NUM_IMAGES);

    typedef enum logic [1:0] {IDLE, DETACH, ARM, BOOT} state_e;

    state_e           state_q;
    logic             btn_s1_q, btn_s2_q;
    logic             deb_q, deb_d, deb_prev_q;
    logic [DBW-1:0]   db_cnt_q, db_cnt_d;
    logic [LPW-1:0]   press_cnt_q, press_cnt_d;
    logic [TOW-1:0]   to_cnt_q, to_cnt_d;
    logic [SQW-1:0]   seq_cnt_q;
    logic [1:0]       tgt_q, req_tgt, trig_tgt;
    logic             btn_raw, deb_rise, deb_fall, idle;
    logic             long_press, short_press, timeout, to_clear, trigger;

    assign btn_raw  = ~btn_s2_q;
    assign deb_rise = deb_q & ~deb_prev_q;
    assign deb_fall = ~deb_q & deb_prev_q;
    assign idle     = (state_q == IDLE);

    // Counter only advances while the synchronised level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the stability window.
    always_comb begin
        db_cnt_d = '0;
        deb_d    = deb_q;
        if (btn_raw != deb_q) begin
            if (db_cnt_q == DB_LAST) deb_d = btn_raw;
            else                     db_cnt_d = db_cnt_q + DBW'(1);
        end
    end

    always_comb begin
        press_cnt_d = '0;
        if (deb_q) press_cnt_d = (press_cnt_q == LP_MAX) ? LP_MAX : press_cnt_q + LPW'(1);
    end

    // press_cnt_q still holds the final pressed count in the cycle the release is seen.
    assign long_press  = deb_q && (press_cnt_q == LP_LAST);
    assign short_press = deb_fall && (press_cnt_q != LP_MAX);

    assign to_clear = activity | boot_req | deb_rise | deb_fall | deb_q;
    assign timeout  = (TIMEOUT_CYCLES != 0) && idle && !to_clear && (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d = '0;
        if (TIMEOUT_CYCLES != 0 && idle && !to_clear)
            to_cnt_d = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + TOW'(1);
    end

    always_comb begin
        req_tgt = boot_req_image;
        if (boot_req_image == 2'd0)                  req_tgt = image_sel;
        else if ({1'b0, boot_req_image} >= NUM_IMG3) req_tgt = LAST_IMG;
    end

    assign trig_tgt = boot_req ? req_tgt : image_sel;
    assign trigger  = boot_req | long_press | timeout;

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            btn_s1_q    <= 1'b1;
            btn_s2_q    <= 1'b1;
            deb_q       <= 1'b0;
            deb_prev_q  <= 1'b0;
            db_cnt_q    <= '0;
            press_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            btn_s1_q    <= btn_n;
            btn_s2_q    <= btn_s1_q;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q;
            db_cnt_q    <= db_cnt_d;
            press_cnt_q <= press_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            seq_cnt_q     <= '0;
            tgt_q         <= 2'd0;
            image_sel     <= DEF_IMG;
            usb_detach    <= 1'b0;
            warmboot_s    <= 2'd0;
            warmboot_boot <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q    <= DETACH;
                        tgt_q      <= trig_tgt;
                        seq_cnt_q  <= '0;
                        usb_detach <= 1'b1;
                        busy       <= 1'b1;
                    end else if (short_press) begin
                        image_sel <= (image_sel == LAST_IMG) ? 2'd1 : image_sel + 2'd1;
                    end
                end
                DETACH: begin
                    if (seq_cnt_q == DET_LAST) begin
                        state_q    <= ARM;
                        seq_cnt_q  <= '0;
                        warmboot_s <= tgt_q;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + SQW'(1);
                    end
                end
                ARM: begin
                    if (seq_cnt_q == ARM_LAST) begin
                        state_q       <= BOOT;
                        seq_cnt_q     <= '0;
                        warmboot_boot <= 1'b1;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + SQW'(1);
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Directed bench: dut_a (4 images, 50-cycle timeout) and dut_b (2 images, no timeout)
// share stimulus; boot targets and button selections go through scoreboard queues.
module tb_warmboot_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       boot_req = 1'b0;
    logic [1:0] boot_req_image = 2'd0;
    logic       activity = 1'b0;
    logic       btn_n = 1'b1;

    logic [1:0] a_sel, a_s, b_sel, b_s;
    logic       a_usb, a_boot, a_busy, b_usb, b_boot, b_busy;

    int total = 0;
    int bad   = 0;
    logic [1:0] boot_q[$];
    logic [1:0] sel_q[$];

    always #5 clk = ~clk;

    warmboot_sequencer #(
        .NUM_IMAGES(4), .DEFAULT_IMAGE(1), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20),
        .TIMEOUT_CYCLES(50), .DETACH_CYCLES(8), .ARM_CYCLES(2)
    ) dut_a (
        .clk_48mhz(clk), .reset(reset), .boot_req(boot_req), .boot_req_image(boot_req_image),
        .activity(activity), .btn_n(btn_n), .image_sel(a_sel), .usb_detach(a_usb),
        .warmboot_s(a_s), .warmboot_boot(a_boot), .busy(a_busy)
    );

    warmboot_sequencer #(
        .NUM_IMAGES(2), .DEFAULT_IMAGE(1), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20),
        .TIMEOUT_CYCLES(0), .DETACH_CYCLES(8), .ARM_CYCLES(2)
    ) dut_b (
        .clk_48mhz(clk), .reset(reset), .boot_req(boot_req), .boot_req_image(boot_req_image),
        .activity(activity), .btn_n(btn_n), .image_sel(b_sel), .usb_detach(b_usb),
        .warmboot_s(b_s), .warmboot_boot(b_boot), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sel"},  32'(a_sel),  32'd1);
        chk({tag, "_usb"},  32'(a_usb),  32'd0);
        chk({tag, "_s"},    32'(a_s),    32'd0);
        chk({tag, "_boot"}, 32'(a_boot), 32'd0);
        chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        cyc(2);
        chk_idle(tag);
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic pulse_req(input logic [1:0] img);
        boot_req = 1'b1;
        boot_req_image = img;
        @(negedge clk);
        boot_req = 1'b0;
        boot_req_image = 2'd0;
    endtask

    task automatic wait_detach(input int budget, output int n);
        n = 0;
        while (n < budget && !a_usb) begin
            @(negedge clk);
            n++;
        end
        if (!a_usb) n = -1;
    endtask

    task automatic press(input int len);
        btn_n = 1'b0;
        cyc(len);
        btn_n = 1'b1;
        cyc(12);
    endtask

    // Called at the first negedge after the trigger edge; follows the whole sequence.
    task automatic boot_follow(input string tag);
        logic [1:0] e;
        total++;
        assert (boot_q.size() > 0) else begin
            bad++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        e = (boot_q.size() > 0) ? boot_q.pop_front() : 2'd0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge clk);
            chk($sformatf("%s_k%0d_usb", tag, k),  32'(a_usb),  32'd1);
            chk($sformatf("%s_k%0d_busy", tag, k), 32'(a_busy), 32'd1);
            chk($sformatf("%s_k%0d_s", tag, k),    32'(a_s),    (k >= 9) ? 32'(e) : 32'd0);
            chk($sformatf("%s_k%0d_boot", tag, k), 32'(a_boot), (k == 11) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int n;
        activity = 1'b1;
        cyc(3);
        chk_idle("rst");
        chk("rst_b_sel", 32'(b_sel), 32'd1);
        reset = 1'b0;
        cyc(2);

        // Host request to image 3; dut_b only has 2 images so it clamps to 1.
        boot_q.push_back(2'd3);
        pulse_req(2'd3);
        boot_follow("req3");
        chk("clamp_b_s",    32'(b_s),    32'd1);
        chk("clamp_b_boot", 32'(b_boot), 32'd1);
        do_reset("rst1");

        // Short presses cycle 2, 3, 1; a 2-cycle glitch is filtered out.
        sel_q.push_back(2'd2);
        sel_q.push_back(2'd3);
        sel_q.push_back(2'd1);
        for (int i = 0; i < 3; i++) begin
            press(10);
            chk($sformatf("short%0d_sel", i), 32'(a_sel), 32'(sel_q.pop_front()));
            chk($sformatf("short%0d_busy", i), 32'(a_busy), 32'd0);
        end
        chk("short_b_sel", 32'(b_sel), 32'd1);
        press(2);
        chk("glitch_sel", 32'(a_sel), 32'd1);

        // Long press boots the current selection; the later release does not reselect.
        press(10);
        chk("pre_long_sel", 32'(a_sel), 32'd2);
        boot_q.push_back(2'd2);
        btn_n = 1'b0;
        wait_detach(40, n);
        chk("long_lat", 32'(n), 32'd26);
        boot_follow("long");
        btn_n = 1'b1;
        cyc(12);
        chk("long_rel_sel",  32'(a_sel),  32'd2);
        chk("long_rel_boot", 32'(a_boot), 32'd1);
        do_reset("rst2");

        // Inactivity timeout.
        activity = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(39);
            chk($sformatf("to_act%0d_busy", i), 32'(a_busy), 32'd0);
            activity = 1'b1;
            @(negedge clk);
            activity = 1'b0;
        end
        boot_q.push_back(2'd1);
        wait_detach(80, n);
        chk("to_lat", 32'(n), 32'd50);
        chk("to_b_busy", 32'(b_busy), 32'd0);
        boot_follow("to");
        cyc(100);
        chk("to0_b_busy", 32'(b_busy), 32'd0);
        do_reset("rst3");
        activity = 1'b1;

        // boot_req with image 0 in the same cycle long_press fires.
        press(10);
        chk("both_pre_sel", 32'(a_sel), 32'd2);
        btn_n = 1'b0;
        cyc(25);
        chk("both_pre_usb", 32'(a_usb), 32'd0);
        boot_q.push_back(2'd2);
        pulse_req(2'd0);
        boot_follow("both");
        btn_n = 1'b1;
        chk("both_b_s", 32'(b_s), 32'd1);
        cyc(12);
        do_reset("rst4");

        // Asynchronous reset mid-DETACH and mid-BOOT.
        pulse_req(2'd2);
        cyc(3);
        chk("mid_det_usb", 32'(a_usb), 32'd1);
        #2 reset = 1'b1;
        #1 chk_idle("async_det");
        @(negedge clk);
        reset = 1'b0;
        cyc(2);
        pulse_req(2'd3);
        cyc(11);
        chk("mid_boot_boot", 32'(a_boot), 32'd1);
        #2 reset = 1'b1;
        #1 chk_idle("async_boot");
        @(negedge clk);
        reset = 1'b0;
        cyc(2);
        boot_q.push_back(2'd2);
        pulse_req(2'd2);
        boot_follow("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
